warp_scheduler: RTL and testbench

WARP_SCHEDULER -- requirements
Module: warp_scheduler

---
 rtl/warp_scheduler_if.sv | 33 +++
 rtl/warp_scheduler.sv | 164 ++++++++++++++++
 tb/tb_warp_scheduler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/warp_scheduler_if.sv
// Bundle of the scheduler's block-launch, context-storage and core-control signals.
// The master side is the scheduler; the slave side is the core / warp storage.
interface warp_scheduler_if #(
  parameter int NUM_WARPS_PER_CORE = 2
);
  localparam int SEL_W = (NUM_WARPS_PER_CORE > 1) ? $clog2(NUM_WARPS_PER_CORE) : 1;

  logic                            start;
  logic [NUM_WARPS_PER_CORE-1:0]   warp_active;
  logic [2:0]                      core_state;
  logic [3*NUM_WARPS_PER_CORE-1:0] warp_state_in;
  logic [8*NUM_WARPS_PER_CORE-1:0] warp_pc_in;
  logic [NUM_WARPS_PER_CORE-1:0]   mem_pending;
  logic [SEL_W-1:0]                warp_select;
  logic                            restore_valid;
  logic [7:0]                      restore_pc;
  logic [2:0]                      restore_state;
  logic                            save_valid;
  logic [NUM_WARPS_PER_CORE-1:0]   warp_reset;
  logic                            done;

  modport master (
    input  start, warp_active, core_state, warp_state_in, warp_pc_in, mem_pending,
    output warp_select, restore_valid, restore_pc, restore_state, save_valid,
           warp_reset, done
  );

  modport slave (
    output start, warp_active, core_state, warp_state_in, warp_pc_in, mem_pending,
    input  warp_select, restore_valid, restore_pc, restore_state, save_valid,
           warp_reset, done
  );
endinterface

// File: rtl/warp_scheduler.sv
// Multiplexes several warps onto one core: switches on memory stalls, quantum expiry
// at instruction boundaries and warp completion, using a SAVE/RESTORE context handoff.
module warp_scheduler #(
  parameter int NUM_WARPS_PER_CORE = 2,
  parameter int QUANTUM            = 16
) (
  input  logic              clk,
  input  logic              reset,
  warp_scheduler_if.master  bus
);
  localparam int N     = NUM_WARPS_PER_CORE;
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(QUANTUM + 2);

  localparam logic [2:0] CS_IDLE   = 3'd0;
  localparam logic [2:0] CS_WAIT   = 3'd4;
  localparam logic [2:0] CS_UPDATE = 3'd6;
  localparam logic [2:0] CS_DONE   = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_SAVE, S_RESTORE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] warp_select_q, warp_select_d;
  logic [SEL_W-1:0] next_q, next_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fin_q, fin_d;
  logic             save_valid_q, save_valid_d;
  logic             restore_valid_q, restore_valid_d;
  logic             done_q, done_d;
  logic [7:0]       restore_pc_q, restore_pc_d;
  logic [2:0]       restore_state_q, restore_state_d;
  logic [N-1:0]     warp_reset_q, warp_reset_d;

  logic [N-1:0]     alive, elig, cur_mask, alive_other, elig_other;
  logic [8*N-1:0]   pc_sh;
  logic [3*N-1:0]   st_sh;
  logic             trigger;

  function automatic logic [SEL_W-1:0] lowest_set(input logic [N-1:0] mask);
    logic [N-1:0] sh;
    lowest_set = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sh = mask >> i;
      if (sh[0]) lowest_set = SEL_W'(i);
    end
  endfunction

  // First set bit of mask after cur in round-robin order, wrapping past N-1 to 0.
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] cur,
                                               input logic [N-1:0]     mask);
    logic [N-1:0] sh;
    int           idx;
    rr_next = cur;
    for (int k = N - 1; k >= 1; k--) begin
      idx = (int'(cur) + k) % N;
      sh  = mask >> idx;
      if (sh[0]) rr_next = SEL_W'(idx);
    end
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      alive[i] = bus.warp_active[i] && (bus.warp_state_in[3*i +: 3] != CS_DONE);
      elig[i]  = alive[i] && !bus.mem_pending[i];
    end
    cur_mask    = {{(N-1){1'b0}}, 1'b1} << warp_select_q;
    alive_other = alive & ~cur_mask;
    elig_other  = elig & ~cur_mask;
    trigger     = (bus.core_state == CS_WAIT) ||
                  ((QUANTUM != 0) && (cnt_q == CNT_W'(QUANTUM)) &&
                   (bus.core_state == CS_UPDATE));
    pc_sh       = bus.warp_pc_in >> (8 * int'(next_q));
    st_sh       = bus.warp_state_in >> (3 * int'(next_q));
  end

  always_comb begin
    state_d         = state_q;
    warp_select_d   = warp_select_q;
    next_d          = next_q;
    cnt_d           = cnt_q;
    fin_d           = fin_q;
    restore_pc_d    = restore_pc_q;
    restore_state_d = restore_state_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d       = S_INIT;
          warp_select_d = lowest_set(bus.warp_active);
          next_d        = lowest_set(bus.warp_active);
          fin_d         = (bus.warp_active == '0);
        end
      end
      S_INIT:    state_d = fin_q ? S_DONE : S_RESTORE;
      S_RUN: begin
        if (bus.core_state == CS_DONE) begin
          // Prefer a ready warp; a stalled-but-live one still gets the core and re-stalls.
          state_d = S_SAVE;
          next_d  = (elig_other != '0) ? rr_next(warp_select_q, elig_other)
                                       : rr_next(warp_select_q, alive_other);
          fin_d   = (alive_other == '0);
        end else if (trigger && (elig_other != '0)) begin
          state_d = S_SAVE;
          next_d  = rr_next(warp_select_q, elig_other);
          fin_d   = 1'b0;
        end else if (!trigger && (cnt_q != CNT_W'(QUANTUM))) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAVE:    state_d = fin_q ? S_DONE : S_RESTORE;
      S_RESTORE: state_d = S_RUN;
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase

    if (state_d == S_RESTORE) begin
      warp_select_d   = next_q;
      restore_pc_d    = pc_sh[7:0];
      restore_state_d = st_sh[2:0];
      cnt_d           = '0;
    end

    save_valid_d    = (state_d == S_SAVE);
    restore_valid_d = (state_d == S_RESTORE);
    done_d          = (state_d == S_DONE);
    warp_reset_d    = (state_d == S_INIT) ? bus.warp_active : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      warp_select_q   <= '0;
      next_q          <= '0;
      cnt_q           <= '0;
      fin_q           <= 1'b0;
      save_valid_q    <= 1'b0;
      restore_valid_q <= 1'b0;
      done_q          <= 1'b0;
      restore_pc_q    <= '0;
      restore_state_q <= CS_IDLE;
      warp_reset_q    <= '1;
    end else begin
      state_q         <= state_d;
      warp_select_q   <= warp_select_d;
      next_q          <= next_d;
      cnt_q           <= cnt_d;
      fin_q           <= fin_d;
      save_valid_q    <= save_valid_d;
      restore_valid_q <= restore_valid_d;
      done_q          <= done_d;
      restore_pc_q    <= restore_pc_d;
      restore_state_q <= restore_state_d;
      warp_reset_q    <= warp_reset_d;
    end
  end

  assign bus.warp_select   = warp_select_q;
  assign bus.save_valid    = save_valid_q;
  assign bus.restore_valid = restore_valid_q;
  assign bus.restore_pc    = restore_pc_q;
  assign bus.restore_state = restore_state_q;
  assign bus.warp_reset    = warp_reset_q;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_warp_scheduler.sv
// Bench for warp_scheduler: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural scheduling model.
module tb_warp_scheduler;
  localparam int N = 3;
  localparam int Q = 4;

  localparam int P_IDLE = 0, P_INIT = 1, P_RUN = 2, P_SAVE = 3, P_RESTORE = 4, P_DONE = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  warp_scheduler_if #(.NUM_WARPS_PER_CORE(N)) bus ();
  warp_scheduler #(.NUM_WARPS_PER_CORE(N), .QUANTUM(Q)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which warp owns the core, what phase of a switch we are in,
  // and how many RUN cycles the owner has consumed.
  int m_phase = P_IDLE, m_cur = 0, m_next = 0, m_runs = 0;
  bit m_fin = 0, m_valid = 0;
  int e_sel = 0, e_rpc = 0, e_rst = 0, e_wr = 0;
  bit e_sv = 0, e_rv = 0, e_done = 0;

  task automatic model_step();
    bit el[N];
    bit al[N];
    int pick_el, pick_al, j, prev;
    bit is_trig;
    if (!reset) begin
      m_valid = 1; m_phase = P_IDLE; m_cur = 0; m_runs = 0;
      e_rpc = 0; e_rst = 0; e_wr = (1 << N) - 1;
      e_sv = 0; e_rv = 0; e_done = 0; e_sel = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        al[i] = bus.warp_active[i] && (bus.warp_state_in[3*i +: 3] != 3'd7);
        el[i] = al[i] && !bus.mem_pending[i];
      end
      pick_el = -1; pick_al = -1;
      for (int k = 1; k < N; k++) begin
        j = (m_cur + k) % N;
        if (el[j] && pick_el < 0) pick_el = j;
        if (al[j] && pick_al < 0) pick_al = j;
      end
      is_trig = (bus.core_state == 3'd4) ||
                (Q != 0 && m_runs == Q && bus.core_state == 3'd6);
      prev = m_phase;
      e_wr = 0;
      case (m_phase)
        P_IDLE: if (bus.start) begin
          m_phase = P_INIT;
          e_wr    = int'(bus.warp_active);
          m_cur   = 0;
          for (int i = N - 1; i >= 0; i--) if (bus.warp_active[i]) m_cur = i;
          m_next  = m_cur;
          m_fin   = (bus.warp_active == 0);
        end
        P_INIT:    m_phase = m_fin ? P_DONE : P_RESTORE;
        P_RUN: begin
          if (bus.core_state == 3'd7) begin
            m_phase = P_SAVE;
            m_next  = (pick_el >= 0) ? pick_el : pick_al;
            m_fin   = (pick_al < 0);
          end else if (is_trig && pick_el >= 0) begin
            m_phase = P_SAVE;
            m_next  = pick_el;
            m_fin   = 0;
          end else if (!is_trig) begin
            m_runs = (m_runs + 1 > Q) ? Q : m_runs + 1;
          end
        end
        P_SAVE:    m_phase = m_fin ? P_DONE : P_RESTORE;
        P_RESTORE: m_phase = P_RUN;
        default:   m_phase = P_DONE;
      endcase
      if (m_phase == P_RESTORE && prev != P_RESTORE) begin
        m_cur  = m_next;
        e_rpc  = int'(bus.warp_pc_in[8*m_cur +: 8]);
        e_rst  = int'(bus.warp_state_in[3*m_cur +: 3]);
        m_runs = 0;
      end
      e_sv   = (m_phase == P_SAVE);
      e_rv   = (m_phase == P_RESTORE);
      e_done = (m_phase == P_DONE);
      e_sel  = m_cur;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_sel",   32'(bus.warp_select),   32'(e_sel));
      check("m_sv",    32'(bus.save_valid),    32'(e_sv));
      check("m_rv",    32'(bus.restore_valid), 32'(e_rv));
      check("m_rpc",   32'(bus.restore_pc),    32'(e_rpc));
      check("m_rst",   32'(bus.restore_state), 32'(e_rst));
      check("m_wr",    32'(bus.warp_reset),    32'(e_wr));
      check("m_done",  32'(bus.done),          32'(e_done));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_states(input logic [2:0] s2, input logic [2:0] s1, input logic [2:0] s0);
    bus.warp_state_in = {s2, s1, s0};
  endtask

  int rst_hold = 0;
  int r;

  initial begin
    bus.start = 0; bus.warp_active = '0; bus.core_state = 3'd0;
    bus.warp_state_in = '0; bus.warp_pc_in = '0; bus.mem_pending = '0;

    // reset state
    reset = 0; step(); step();
    check("rst_wr", 32'(bus.warp_reset), 32'h7);
    check("rst_sel", 32'(bus.warp_select), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_sv", 32'(bus.save_valid), 0);
    check("rst_rv", 32'(bus.restore_valid), 0);
    check("rst_rpc", 32'(bus.restore_pc), 0);
    check("rst_rst", 32'(bus.restore_state), 0);
    reset = 1; step();
    check("post_rst_wr", 32'(bus.warp_reset), 0);

    // launch with warps 0 and 1
    bus.warp_active = 3'b011; set_states(3'd1, 3'd1, 3'd1);
    bus.warp_pc_in = {8'h2a, 8'h12, 8'h05}; bus.core_state = 3'd1; bus.start = 1;
    step(); bus.start = 0;
    check("init_wr", 32'(bus.warp_reset), 32'h3);
    step();
    check("init_rv", 32'(bus.restore_valid), 1);
    check("init_sel", 32'(bus.warp_select), 0);
    check("init_rpc", 32'(bus.restore_pc), 32'h05);
    step();
    check("run_rv", 32'(bus.restore_valid), 0);

    // memory stall on warp 0 hands the core to warp 1
    bus.core_state = 3'd4; bus.mem_pending = 3'b001; step();
    check("wait_sv", 32'(bus.save_valid), 1);
    check("wait_sel", 32'(bus.warp_select), 0);
    bus.core_state = 3'd1; step();
    check("wait_rv", 32'(bus.restore_valid), 1);
    check("wait_sel1", 32'(bus.warp_select), 1);
    check("wait_rpc", 32'(bus.restore_pc), 32'h12);
    step();

    // both stalled: stay on warp 1 until warp 0's memory returns
    bus.core_state = 3'd4; bus.mem_pending = 3'b011;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_sv", 32'(bus.save_valid), 0);
      check("hold_sel", 32'(bus.warp_select), 1);
    end
    bus.mem_pending = 3'b010; step();
    check("unhold_sv", 32'(bus.save_valid), 1);
    bus.core_state = 3'd1; bus.mem_pending = 3'b000; step();
    check("unhold_rv", 32'(bus.restore_valid), 1);
    check("unhold_sel", 32'(bus.warp_select), 0);
    step();

    // quantum expiry at UPDATE, alternating 0 -> 1 -> 0 (warp 2 inactive, wraps)
    bus.core_state = 3'd6;
    for (int rr = 0; rr < 2; rr++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        check("q_nosw", 32'(bus.save_valid), 0);
      end
      step();
      check("q_sv", 32'(bus.save_valid), 1);
      step();
      check("q_rv", 32'(bus.restore_valid), 1);
      check("q_sel", 32'(bus.warp_select), (rr == 0) ? 1 : 0);
      step();
    end

    // warp 1 finishes while warp 0 is already done -> block done
    bus.core_state = 3'd4; step();
    check("d_sv0", 32'(bus.save_valid), 1);
    bus.core_state = 3'd1; step();
    check("d_sel1", 32'(bus.warp_select), 1);
    step();
    set_states(3'd1, 3'd1, 3'd7); bus.core_state = 3'd7; step();
    check("d_sv", 32'(bus.save_valid), 1);
    step();
    check("d_done", 32'(bus.done), 1);
    check("d_rv", 32'(bus.restore_valid), 0);
    bus.start = 1; step(); bus.start = 0;
    check("d_hold", 32'(bus.done), 1);
    check("d_wr", 32'(bus.warp_reset), 0);
    reset = 0; step(); reset = 1;
    check("d_clr", 32'(bus.done), 0);

    // reset arriving mid-SAVE aborts the switch
    set_states(3'd1, 3'd1, 3'd1); bus.core_state = 3'd1; bus.start = 1; step();
    bus.start = 0; step(); step();
    bus.core_state = 3'd7; step();
    check("ms_sv", 32'(bus.save_valid), 1);
    reset = 0; step();
    check("ms_sv0", 32'(bus.save_valid), 0);
    check("ms_wr", 32'(bus.warp_reset), 32'h7);
    check("ms_done", 32'(bus.done), 0);
    reset = 1; step();
    check("ms_wr0", 32'(bus.warp_reset), 0);
    step();
    check("ms_rv", 32'(bus.restore_valid), 0);

    // empty block goes straight to done
    bus.warp_active = 3'b000; bus.start = 1; step(); bus.start = 0;
    check("e_wr", 32'(bus.warp_reset), 0);
    step();
    check("e_done", 32'(bus.done), 1);

    // randomized traffic
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (rst_hold > 0) begin
        reset = 0; rst_hold--;
      end else if ((m_phase == P_DONE && $urandom_range(0, 3) == 0) ||
                   $urandom_range(0, 199) == 0) begin
        reset = 0; rst_hold = $urandom_range(0, 1);
        bus.warp_active = ($urandom_range(0, 7) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      end else begin
        reset = 1;
      end
      bus.start = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 99);
      if (r < 2)       bus.core_state = 3'd7;
      else if (r < 30) bus.core_state = 3'd4;
      else if (r < 60) bus.core_state = 3'd6;
      else begin
        r = $urandom_range(0, 4);
        bus.core_state = (r == 4) ? 3'd5 : 3'(r);
      end
      for (int i = 0; i < N; i++) begin
        bus.mem_pending[i] = ($urandom_range(0, 3) == 0);
        bus.warp_state_in[3*i +: 3] = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        bus.warp_pc_in[8*i +: 8] = 8'($urandom_range(0, 255));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
